// File: rtl/div_ctrl.sv
// Iterative 32-bit DIV/DIVU controller: radix-2 restoring divider with annul and stall handshake.
// Define DIV_ZERO_FAST_EN to short-circuit zero divisors through DIVZERO with a zero result.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, divisor;
  logic        is_signed, sign1, sign2;

  logic [31:0] abs1, abs2;
  logic [32:0] shifted, sub;
  logic        ge, take, zero_fast;
  logic [31:0] fix_quo, fix_rem;

  assign take      = start_i && !annul_i;
  assign zero_fast = FAST_ZERO && (opdata2_i == 32'd0);
  assign abs1      = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2      = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // rem < divisor always holds, so a 33-bit window never overflows; bit 32 of sub is the borrow
  assign shifted = {rem, quo[31]};
  assign sub     = shifted - {1'b0, divisor};
  assign ge      = ~sub[32];

  assign fix_quo = (is_signed && (sign1 ^ sign2)) ? (~quo + 32'd1) : quo;
  assign fix_rem = (is_signed && sign1) ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = zero_fast ? DIVZERO : BUSY;
      BUSY:    if (annul_i) state_nx = IDLE;
               else if (cnt == 6'd32) state_nx = DONE;
      DIVZERO: state_nx = annul_i ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // 32 shift/subtract steps (cnt 0..31); the cycle with cnt==32 hands over to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 6'd0;
      rem       <= 32'd0;
      quo       <= 32'd0;
      divisor   <= 32'd0;
      is_signed <= 1'b0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
    end else if (state == IDLE) begin
      if (take) begin
        cnt       <= 6'd0;
        rem       <= 32'd0;
        quo       <= zero_fast ? 32'd0 : abs1;
        divisor   <= abs2;
        is_signed <= signed_i;
        sign1     <= opdata1_i[31];
        sign2     <= opdata2_i[31];
      end
    end else if (state == BUSY && !annul_i && cnt != 6'd32) begin
      rem <= ge ? sub[31:0] : shifted[31:0];
      quo <= {quo[30:0], ge};
      cnt <= cnt + 6'd1;
    end
  end

  always_comb begin
    ready_o    = (state == DONE);
    result_o   = (state == DONE) ? {fix_rem, fix_quo} : 64'd0;
    stallreq_o = !rst && start_i && !annul_i && (state != DONE);
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, signed fixup, zero divisor, annul and reset.
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int total = 0;
  int bad = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // Drives one request and returns edges-after-sampling until ready, the result seen,
  // whether stall stayed high while waiting, and stall in the ready cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int lat, output logic [63:0] res,
                         output logic stall_ok, output logic stall_done);
    lat = -1; res = 64'd0; stall_ok = 1'b1; stall_done = 1'bx;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_i = sgn; start_i = 1'b1;
    #1 if (stallreq_o !== 1'b1) stall_ok = 1'b0;
    for (int e = 0; e < 100; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o === 1'b1) begin
        lat = e; res = result_o; stall_done = stallreq_o;
        break;
      end
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
    start_i = 1'b0;
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o !== 1'b0) pulses++;
    end
  endtask

  task automatic test_reset;
    start_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", ready_o); end
    total++; if (result_o !== 64'd0) begin bad++; $display("[TB] FAIL reset_result got=%h exp=0", result_o); end
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b exp=0", stallreq_o); end
    start_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu;
    int lat; logic [63:0] res; logic sok, sd;
    run_div(32'd100, 32'd7, 1'b0, lat, res, sok, sd);
    total++; if (lat !== 33) begin bad++; $display("[TB] FAIL divu_latency got=%0d exp=33", lat); end
    total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("[TB] FAIL divu_result got=%h exp=%h", res, {32'd2, 32'd14}); end
    total++; if (sok !== 1'b1) begin bad++; $display("[TB] FAIL divu_stall_wait got=%b exp=1", sok); end
    total++; if (sd !== 1'b0) begin bad++; $display("[TB] FAIL divu_stall_done got=%b exp=0", sd); end
    @(negedge clk);
    total++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin bad++; $display("[TB] FAIL divu_pulse got=%b/%h exp=0/0", ready_o, result_o); end
  endtask

  task automatic test_signed;
    logic [31:0] a [4] = '{32'hFFFFFFF9, 32'h80000000, 32'd7,        32'hFFFFFFF9};
    logic [31:0] b [4] = '{32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [63:0] x [4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'h0, 32'h80000000},
                           {32'h1, 32'hFFFFFFFD}, {32'hFFFFFFFF, 32'h3}};
    int lat; logic [63:0] res; logic sok, sd;
    for (int i = 0; i < 4; i++) begin
      run_div(a[i], b[i], 1'b1, lat, res, sok, sd);
      total++; if (res !== x[i] || lat !== 33) begin bad++; $display("[TB] FAIL div_signed_%0d got=%h lat=%0d exp=%h lat=33", i, res, lat, x[i]); end
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [63:0] res; logic sok, sd;
    run_div(32'h1234, 32'd0, 1'b0, lat, res, sok, sd);
    if (FAST) begin
      total++; if (lat !== 1 || res !== 64'd0) begin bad++; $display("[TB] FAIL divzero_u got=%h lat=%0d exp=0 lat=1", res, lat); end
    end else begin
      total++; if (lat !== 33 || res !== {32'h1234, 32'hFFFFFFFF}) begin bad++; $display("[TB] FAIL divzero_u got=%h lat=%0d exp=%h lat=33", res, lat, {32'h1234, 32'hFFFFFFFF}); end
    end
    run_div(32'hFFFFFFFB, 32'd0, 1'b1, lat, res, sok, sd);
    if (FAST) begin
      total++; if (lat !== 1 || res !== 64'd0) begin bad++; $display("[TB] FAIL divzero_s got=%h lat=%0d exp=0 lat=1", res, lat); end
    end else begin
      total++; if (lat !== 33 || res !== {32'hFFFFFFFB, 32'h1}) begin bad++; $display("[TB] FAIL divzero_s got=%h lat=%0d exp=%h lat=33", res, lat, {32'hFFFFFFFB, 32'h1}); end
    end
  endtask

  task automatic test_annul;
    int lat, pulses; logic [63:0] res; logic sok, sd;
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    count_ready(40, pulses);
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL annul_busy_ready got=%0d exp=0", pulses); end
    run_div(32'd9, 32'd3, 1'b0, lat, res, sok, sd);
    total++; if (lat !== 33 || res !== {32'd0, 32'd3}) begin bad++; $display("[TB] FAIL annul_restart got=%h lat=%0d exp=%h lat=33", res, lat, {32'd0, 32'd3}); end
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1;
    #1 total++; if (stallreq_o !== 1'b0) begin bad++; $display("[TB] FAIL annul_prio_stall got=%b exp=0", stallreq_o); end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    count_ready(40, pulses);
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL annul_prio_ready got=%0d exp=0", pulses); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    @(negedge clk);
    opdata1_i = 32'd1; opdata2_i = 32'd1; signed_i = 1'b0; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mid_outputs got=%b/%h/%b exp=0/0/0", ready_o, result_o, stallreq_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_ready(40, pulses);
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL reset_mid_ready got=%0d exp=0", pulses); end
  endtask

  task automatic test_operand_change;
    int lat; logic [63:0] res; logic sok, sd;
    fork
      run_div(32'd1000, 32'd10, 1'b0, lat, res, sok, sd);
      begin
        @(posedge clk); @(posedge clk);
        #2 opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd3; signed_i = 1'b1;
      end
    join
    total++; if (lat !== 33 || res !== {32'd0, 32'd100}) begin bad++; $display("[TB] FAIL operand_change got=%h lat=%0d exp=%h lat=33", res, lat, {32'd0, 32'd100}); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [63:0] res; logic sok, sd;
    run_div(32'd20, 32'd6, 1'b0, lat, res, sok, sd);
    total++; if (lat !== 33 || res !== {32'd2, 32'd3}) begin bad++; $display("[TB] FAIL b2b_first got=%h lat=%0d exp=%h", res, lat, {32'd2, 32'd3}); end
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, lat, res, sok, sd);
    total++; if (lat !== 33 || res !== {32'd0, 32'hFFFFFFFF}) begin bad++; $display("[TB] FAIL b2b_second got=%h lat=%0d exp=%h", res, lat, {32'd0, 32'hFFFFFFFF}); end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_signed;
    test_div_zero;
    test_annul;
    test_reset_mid;
    test_operand_change;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port start_i  in  1  EX requests a DIV/DIVU; held high by EX until ready_o.
REQ-004 SHALL have port annul_i  in  1  cancels the in-flight or requested divide (flush/exception).
REQ-005 SHALL have port signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 SHALL have port opdata1_i  in  32  dividend (rs); sampled with start.
REQ-007 SHALL have port opdata2_i  in  32  divisor (rt); sampled with start.
REQ-008 SHALL have port result_o  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL have port ready_o  out  1  result_o valid; one-cycle pulse.
REQ-010 SHALL have port stallreq_o  out  1  pipeline stall request to the stall controller.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE (plus DIVZERO, per REQ-028).
REQ-012 IDLE: start_i=1 and annul_i=0 at an edge SHALL latch |opdata1_i|, |opdata2_i| (magnitudes only when signed_i=1), signed_i and both sign bits; clear the 6-bit iteration counter; go to BUSY.
REQ-013 BUSY SHALL perform one radix-2 restoring step per cycle: shift {rem,quo} left by 1; if rem >= divisor, subtract and set quo[0]=1.
REQ-014 BUSY SHALL leave after exactly 32 steps (counter 0..31) and go to DONE; the 33-bit compare/subtract SHALL not overflow.
REQ-015 DONE SHALL, for one cycle, assert ready_o and drive the final result, then go to IDLE unconditionally; start_i during DONE SHALL be ignored.
REQ-016 Latency: ready_o SHALL be high in the cycle after the 33rd rising edge following the edge that sampled start (34 cycles of stall in total).
REQ-017 Signed fixup: the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-019 annul_i=1 in BUSY or DONE SHALL force IDLE at the next edge with ready_o=0; annul_i has priority over start_i in IDLE.
REQ-020 stallreq_o SHALL be combinational: 1 when start_i=1, annul_i=0 and state != DONE; else 0.
REQ-021 result_o SHALL be 64'b0 whenever ready_o=0.
REQ-022 Operand changes on opdata*_i after sampling SHALL not affect the in-flight divide.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counter 0, internal operand/remainder registers 0.
REQ-024 Under reset, ready_o=0, result_o=64'b0, stallreq_o=0, regardless of start_i.
REQ-025 Reset asserted mid-BUSY SHALL abandon the divide; after release, no ready_o SHALL occur until a new start.

Configuration
REQ-026 Macro DIV_ZERO_FAST_EN SHALL select divide-by-zero handling.
REQ-027 Without DIV_ZERO_FAST_EN: a zero divisor SHALL run all 32 steps; unsigned result = quotient 0xFFFFFFFF, remainder = dividend; signed fixup per REQ-017 then applied.
REQ-028 With DIV_ZERO_FAST_EN: a zero divisor at start SHALL enter DIVZERO for one cycle, then DONE with result_o=64'b0; ready_o is high in the cycle after the 2nd edge; annul/reset rules unchanged.

Verification
REQ-029 DIVU 100 / 7 -> after 33 edges ready_o=1 for 1 cycle, result_o={0x00000002, 0x0000000E}; stallreq_o high throughout the wait.
REQ-030 DIV -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-031 Start DIVU 50/5, annul_i pulsed at BUSY step 10 -> no ready_o; the next start of 9/3 returns {0, 3} with full latency.
REQ-032 rst pulsed at BUSY step 20 -> outputs 0 immediately, IDLE; no spurious ready_o for 40 cycles with start_i=0.
REQ-033 DIVU 0x1234 / 0: without macro -> {0x00001234, 0xFFFFFFFF} after 33 edges; with DIV_ZERO_FAST_EN -> {0, 0} after 2 edges.
